iob_spi_flash_arbiter: RTL and testbench
========================================

Name: iob_spi_flash_arbiter

Overview:
Sequences and shares the single SPI flash controller between two requesters: the read-only cache port (XIP fetches) and the software command port (register-driven flash commands). It latches a request, drives one command transaction into the flash controller, waits for completion, and returns data and a handshake to the winning requester. Fairness is fixed-priority to the cache, bounded by a burst limit so software commands cannot starve.

Parameters:
ADDR_W, 24, cache-port flash address width (24 or 32).
DATA_W, 32, data and command word width.
MAX_CACHE_BURST, 4, maximum consecutive cache grants while a software request is pending (1..15).
TIMEOUT_W, 16, width of the optional watchdog counter.

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cache_valid_i  in  1  cache read request, level, held until cache_ready_o
cache_addr_i  in  ADDR_W  cache read address
cache_cmd_i  in  DATA_W  command word used for cache reads (programmed read opcode/frame)
cache_cmdtp_i  in  DATA_W  command-type word used for cache reads
cache_rdata_o  out  DATA_W  read data, valid when cache_ready_o=1
cache_ready_o  out  1  one-cycle completion pulse to cache
sw_valid_i  in  1  software command start, one-cycle pulse
sw_addr_i  in  DATA_W  software command address
sw_cmd_i  in  DATA_W  software command word
sw_cmdtp_i  in  DATA_W  software command-type word
sw_datain_i  in  DATA_W  software write data
sw_rdata_o  out  DATA_W  software read data, held until next software completion
sw_busy_o  out  1  software request pending or in flight
sw_done_o  out  1  one-cycle completion pulse to software
fl_valid_o  out  1  one-cycle start pulse to flash controller
fl_address_o  out  DATA_W  address to controller (cache address zero-extended)
fl_command_o  out  DATA_W  command word to controller
fl_commandtp_o  out  DATA_W  command-type word to controller
fl_datain_o  out  DATA_W  write data to controller (zero for cache reads)
fl_dataout_i  in  DATA_W  controller read data, valid with fl_tready_i
fl_tready_i  in  1  controller completion pulse
timeout_o  out  1  sticky watchdog flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset (arst_n_i=0, immediate): state IDLE; all outputs 0; sw pending flag 0; burst counter 0; rdata registers 0.
- sw_valid_i sets sw_pending (sw_busy_o=1) next cycle; sw_valid_i while sw_busy_o=1 is ignored (no queueing).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if cache_valid_i and (not sw_pending or burst_cnt<MAX_CACHE_BURST) grant cache; else if sw_pending grant software; else stay. Grant latches owner plus address/command/cmdtp/datain into output registers -> ISSUE.
- ISSUE: fl_valid_o=1 for exactly this cycle -> WAIT. fl_* data outputs stay stable from ISSUE until RESP.
- WAIT: on fl_tready_i capture fl_dataout_i into owner's rdata register -> RESP. fl_tready_i in any other state is ignored.
- RESP: cache owner: cache_ready_o=1 for one cycle; software owner: sw_done_o=1, sw_pending cleared (sw_busy_o=0 next cycle) -> IDLE.
- Latency: grant to fl_valid_o 1 cycle; fl_tready_i to ready/done pulse 1 cycle; minimum IDLE-to-IDLE turnaround 4 cycles plus controller time.
- burst_cnt: increments on each cache grant while sw_pending=1, saturates at MAX_CACHE_BURST, clears on software grant or when sw_pending=0.
- Simultaneous cache_valid_i and sw_pending in IDLE with burst_cnt<limit: cache wins.
- cache_valid_i deasserted mid-transaction: transaction completes; cache_ready_o still pulses.
- Cache address zero-extended to DATA_W; fl_datain_o=0 for cache grants.

Optional Feature:
IOB_SPI_FLASH_ARB_TIMEOUT_EN: defined -> TIMEOUT_W-bit counter runs in WAIT; reaching all-ones without fl_tready_i forces RESP with rdata=all-ones, sets timeout_o (sticky, cleared only by reset). Not defined -> no counter, WAIT waits indefinitely, timeout_o tied 0.

Test Plan:
- Reset mid-WAIT with arst_n_i=0 -> all outputs 0 immediately; after release, fl_valid_o stays 0 with no requests.
- Cache read addr 0x00_1234, controller returns 0xDEADBEEF after 10 cycles -> fl_address_o=0x00001234, one fl_valid_o pulse, cache_ready_o one cycle later with 0xDEADBEEF.
- sw_valid_i pulse with cmd 0x9F, controller returns 0x00C22017 -> sw_busy_o=1, sw_done_o pulse, sw_rdata_o=0x00C22017 held, sw_busy_o=0 next cycle.
- cache_valid_i held continuously, sw_valid_i pulsed, MAX_CACHE_BURST=4 -> exactly 4 cache transactions, then software granted, then cache resumes.
- sw_valid_i pulsed again while sw_busy_o=1 -> ignored; exactly one sw_done_o.
- Macro defined, TIMEOUT_W=4, no fl_tready_i -> after 15 WAIT cycles owner gets ready/done with rdata 0xFFFFFFFF and timeout_o=1 until reset.

Source files
------------

// File: rtl/iob_spi_flash_arbiter.sv
// iob_spi_flash_arbiter: shares one SPI flash controller between the cache (XIP) and software ports.
// Define IOB_SPI_FLASH_ARB_TIMEOUT_EN to add the WAIT watchdog and sticky timeout_o.
module iob_spi_flash_arbiter #(
    parameter int ADDR_W          = 24,
    parameter int DATA_W          = 32,
    parameter int MAX_CACHE_BURST = 4,
    parameter int TIMEOUT_W       = 16
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cache_valid_i,
    input  logic [ADDR_W-1:0] cache_addr_i,
    input  logic [DATA_W-1:0] cache_cmd_i,
    input  logic [DATA_W-1:0] cache_cmdtp_i,
    output logic [DATA_W-1:0] cache_rdata_o,
    output logic              cache_ready_o,
    input  logic              sw_valid_i,
    input  logic [DATA_W-1:0] sw_addr_i,
    input  logic [DATA_W-1:0] sw_cmd_i,
    input  logic [DATA_W-1:0] sw_cmdtp_i,
    input  logic [DATA_W-1:0] sw_datain_i,
    output logic [DATA_W-1:0] sw_rdata_o,
    output logic              sw_busy_o,
    output logic              sw_done_o,
    output logic              fl_valid_o,
    output logic [DATA_W-1:0] fl_address_o,
    output logic [DATA_W-1:0] fl_command_o,
    output logic [DATA_W-1:0] fl_commandtp_o,
    output logic [DATA_W-1:0] fl_datain_o,
    input  logic [DATA_W-1:0] fl_dataout_i,
    input  logic              fl_tready_i,
    output logic              timeout_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int              BC_W      = 4;
    localparam logic [BC_W-1:0] BURST_MAX = BC_W'(MAX_CACHE_BURST);

    state_t            state_q;
    state_t            state_d;
    logic              owner_sw_q;
    logic              sw_pending_q;
    logic [BC_W-1:0]   burst_q;
    logic              grant_cache;
    logic              grant_sw;
    logic              capture;
    logic              tmo_hit;
    logic [DATA_W-1:0] capture_data;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] cmd_q;
    logic [DATA_W-1:0] cmdtp_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] cache_rdata_q;
    logic [DATA_W-1:0] sw_rdata_q;

`ifdef IOB_SPI_FLASH_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    logic [TIMEOUT_W-1:0] tmo_q;
    logic                 tmo_flag_q;

    // Last WAIT cycle before the counter would reach all-ones.
    assign tmo_hit = (state_q == WAIT) && !fl_tready_i && (tmo_q == TMO_LAST);

    // Watchdog counts WAIT cycles; the flag is sticky until reset.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            tmo_q      <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_q      <= (state_q == WAIT) ? tmo_q + 1'b1 : '0;
            tmo_flag_q <= tmo_flag_q | tmo_hit;
        end
    end

    assign timeout_o = tmo_flag_q;
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Fixed priority to cache, unless the burst budget is spent with software waiting.
    always_comb begin
        grant_cache = 1'b0;
        grant_sw    = 1'b0;
        if (state_q == IDLE) begin
            if (cache_valid_i && (!sw_pending_q || burst_q < BURST_MAX)) begin
                grant_cache = 1'b1;
            end else if (sw_pending_q) begin
                grant_sw = 1'b1;
            end
        end
    end

    // Next-state and read-data capture decode.
    always_comb begin
        state_d      = state_q;
        capture      = 1'b0;
        capture_data = fl_dataout_i;
        unique case (state_q)
            IDLE:  if (grant_cache || grant_sw) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (fl_tready_i) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    capture      = 1'b1;
                    capture_data = '1;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Latch the winner's request; held stable until the next grant.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            owner_sw_q <= 1'b0;
            addr_q     <= '0;
            cmd_q      <= '0;
            cmdtp_q    <= '0;
            din_q      <= '0;
        end else if (grant_cache) begin
            owner_sw_q <= 1'b0;
            addr_q     <= DATA_W'(cache_addr_i);
            cmd_q      <= cache_cmd_i;
            cmdtp_q    <= cache_cmdtp_i;
            din_q      <= '0;
        end else if (grant_sw) begin
            owner_sw_q <= 1'b1;
            addr_q     <= sw_addr_i;
            cmd_q      <= sw_cmd_i;
            cmdtp_q    <= sw_cmdtp_i;
            din_q      <= sw_datain_i;
        end
    end

    // Route returned data to the owner's read register.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            cache_rdata_q <= '0;
            sw_rdata_q    <= '0;
        end else if (capture) begin
            if (owner_sw_q) sw_rdata_q    <= capture_data;
            else            cache_rdata_q <= capture_data;
        end
    end

    // Software pending flag: single slot, extra starts while busy are dropped.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sw_pending_q <= 1'b0;
        end else if (state_q == RESP && owner_sw_q) begin
            sw_pending_q <= 1'b0;
        end else if (sw_valid_i) begin
            sw_pending_q <= 1'b1;
        end
    end

    // Count cache grants that jump ahead of a waiting software request.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            burst_q <= '0;
        end else if (!sw_pending_q || grant_sw) begin
            burst_q <= '0;
        end else if (grant_cache && burst_q < BURST_MAX) begin
            burst_q <= burst_q + 1'b1;
        end
    end

    assign fl_valid_o     = (state_q == ISSUE);
    assign fl_address_o   = addr_q;
    assign fl_command_o   = cmd_q;
    assign fl_commandtp_o = cmdtp_q;
    assign fl_datain_o    = din_q;
    assign cache_ready_o  = (state_q == RESP) && !owner_sw_q;
    assign sw_done_o      = (state_q == RESP) && owner_sw_q;
    assign cache_rdata_o  = cache_rdata_q;
    assign sw_rdata_o     = sw_rdata_q;
    assign sw_busy_o      = sw_pending_q;

endmodule

// File: tb/tb_iob_spi_flash_arbiter.sv
// tb_iob_spi_flash_arbiter: directed bench with a transaction-level model
// of the flash controller and both requesters.
module tb_iob_spi_flash_arbiter;

`ifdef IOB_SPI_FLASH_ARB_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 16;
`endif

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b1;
    logic        cache_valid_i = 1'b0;
    logic [23:0] cache_addr_i = '0;
    logic [31:0] cache_cmd_i = '0;
    logic [31:0] cache_cmdtp_i = '0;
    logic [31:0] cache_rdata_o;
    logic        cache_ready_o;
    logic        sw_valid_i = 1'b0;
    logic [31:0] sw_addr_i = '0;
    logic [31:0] sw_cmd_i = '0;
    logic [31:0] sw_cmdtp_i = '0;
    logic [31:0] sw_datain_i = '0;
    logic [31:0] sw_rdata_o;
    logic        sw_busy_o;
    logic        sw_done_o;
    logic        fl_valid_o;
    logic [31:0] fl_address_o;
    logic [31:0] fl_command_o;
    logic [31:0] fl_commandtp_o;
    logic [31:0] fl_datain_o;
    logic [31:0] fl_dataout_i = 32'h5A5A5A5A;
    logic        fl_tready_i = 1'b0;
    logic        timeout_o;

    always #5 clk_i = ~clk_i;

    iob_spi_flash_arbiter #(
        .ADDR_W(24), .DATA_W(32), .MAX_CACHE_BURST(4), .TIMEOUT_W(TW)
    ) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .cache_valid_i(cache_valid_i), .cache_addr_i(cache_addr_i),
        .cache_cmd_i(cache_cmd_i), .cache_cmdtp_i(cache_cmdtp_i),
        .cache_rdata_o(cache_rdata_o), .cache_ready_o(cache_ready_o),
        .sw_valid_i(sw_valid_i), .sw_addr_i(sw_addr_i), .sw_cmd_i(sw_cmd_i),
        .sw_cmdtp_i(sw_cmdtp_i), .sw_datain_i(sw_datain_i),
        .sw_rdata_o(sw_rdata_o), .sw_busy_o(sw_busy_o), .sw_done_o(sw_done_o),
        .fl_valid_o(fl_valid_o), .fl_address_o(fl_address_o),
        .fl_command_o(fl_command_o), .fl_commandtp_o(fl_commandtp_o),
        .fl_datain_o(fl_datain_o), .fl_dataout_i(fl_dataout_i),
        .fl_tready_i(fl_tready_i), .timeout_o(timeout_o)
    );

    typedef struct {
        bit          sw;
        logic [31:0] addr;
        logic [31:0] cmd;
        logic [31:0] cmdtp;
        logic [31:0] din;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        cur;
    int          checks = 0;
    int          failures = 0;
    bit          outstanding = 0;
    bit          issued = 0;
    int          cd = 0;
    int          tmo_left = 0;
    bit          due_valid = 0;
    bit          due_sw = 0;
    bit          due_tmo = 0;
    logic [31:0] due_data = '0;
    logic [31:0] sw_rdata_exp = '0;
    bit          busy_exp = 0;
    bit          tmo_exp = 0;
    bit          spur = 0;
    bit          resp_now = 0;
    bit          sw_now = 0;
    bit          busy_nxt = 0;
    int          issue_cnt = 0;
    int          resp_cnt = 0;
    int          sw_done_cnt = 0;
    logic [31:0] owner_log = '0;
    logic [31:0] last_issue_addr = '0;
    logic [31:0] last_cache_data = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        chk(name, 32'(act), 32'(exp));
    endtask

    function automatic void push(bit sw, logic [31:0] a, logic [31:0] c,
                                 logic [31:0] t, logic [31:0] d,
                                 logic [31:0] r, int lat);
        txn_t x;
        x.sw = sw; x.addr = a; x.cmd = c; x.cmdtp = t;
        x.din = d; x.rdata = r; x.lat = lat;
        exp_q.push_back(x);
    endfunction

    // Controller model plus per-cycle comparison of every DUT output.
    always @(negedge clk_i) begin
        if (!arst_n_i) begin
            outstanding  = 0;
            due_valid    = 0;
            busy_exp     = 0;
            sw_rdata_exp = '0;
            tmo_exp      = 0;
            fl_tready_i  = 1'b0;
            fl_dataout_i = 32'h5A5A5A5A;
        end else begin
            resp_now = due_valid;
            sw_now   = due_valid && due_sw;
            issued   = 0;
            if (resp_now && due_tmo) tmo_exp = 1;
            if (sw_now) sw_rdata_exp = due_data;
            chk1("cache_ready", cache_ready_o, resp_now && !due_sw);
            chk1("sw_done", sw_done_o, sw_now);
            if (resp_now && !due_sw) chk("cache_rdata", cache_rdata_o, due_data);
            chk("sw_rdata", sw_rdata_o, sw_rdata_exp);
            chk1("sw_busy", sw_busy_o, busy_exp);
            chk1("timeout", timeout_o, tmo_exp);
            if (cache_ready_o) last_cache_data = cache_rdata_o;
            if (sw_done_o) sw_done_cnt++;
            if (outstanding) begin
                chk("fl_address_stable", fl_address_o, cur.addr);
                chk("fl_command_stable", fl_command_o, cur.cmd);
                chk("fl_commandtp_stable", fl_commandtp_o, cur.cmdtp);
                chk("fl_datain_stable", fl_datain_o, cur.din);
            end
            if (resp_now) begin
                outstanding = 0;
                resp_cnt++;
            end
            due_valid = 0;
            if (outstanding || exp_q.size() == 0) begin
                chk1("fl_valid_unexpected", fl_valid_o, 1'b0);
            end else if (fl_valid_o) begin
                cur = exp_q.pop_front();
                chk("fl_address", fl_address_o, cur.addr);
                chk("fl_command", fl_command_o, cur.cmd);
                chk("fl_commandtp", fl_commandtp_o, cur.cmdtp);
                chk("fl_datain", fl_datain_o, cur.din);
                last_issue_addr = fl_address_o;
                owner_log = {owner_log[30:0], cur.sw};
                outstanding = 1;
                issued = 1;
                cd = cur.lat;
                tmo_left = 15;
                issue_cnt++;
            end
            fl_tready_i  = 1'b0;
            fl_dataout_i = 32'h5A5A5A5A;
            if (outstanding && !issued) begin
                if (cur.lat > 0) begin
                    cd--;
                    if (cd == 0) begin
                        fl_tready_i  = 1'b1;
                        fl_dataout_i = cur.rdata;
                        due_valid = 1; due_sw = cur.sw;
                        due_data = cur.rdata; due_tmo = 0;
                    end
                end else begin
                    tmo_left--;
                    if (tmo_left == 0) begin
                        due_valid = 1; due_sw = cur.sw;
                        due_data = 32'hFFFFFFFF; due_tmo = 1;
                    end
                end
            end else if (!outstanding && spur) begin
                fl_tready_i  = 1'b1;
                fl_dataout_i = 32'h0BADF00D;
            end
            busy_nxt = busy_exp;
            if (sw_valid_i && !busy_exp) busy_nxt = 1;
            if (sw_now) busy_nxt = 0;
            busy_exp = busy_nxt;
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_resp(int n, string name);
        int b = 0;
        while (resp_cnt < n && b < 500) begin
            @(posedge clk_i);
            b++;
        end
        #1;
        if (resp_cnt < n) chk(name, 32'(resp_cnt), 32'(n));
    endtask

    task automatic wait_issue(int n);
        int b = 0;
        while (issue_cnt < n && b < 500) begin
            @(posedge clk_i);
            b++;
        end
        #1;
        if (issue_cnt < n) chk("issue_timeout", 32'(issue_cnt), 32'(n));
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_cache_rdata"}, cache_rdata_o, 32'h0);
        chk1({tag, "_cache_ready"}, cache_ready_o, 1'b0);
        chk({tag, "_sw_rdata"}, sw_rdata_o, 32'h0);
        chk1({tag, "_sw_busy"}, sw_busy_o, 1'b0);
        chk1({tag, "_sw_done"}, sw_done_o, 1'b0);
        chk1({tag, "_fl_valid"}, fl_valid_o, 1'b0);
        chk({tag, "_fl_address"}, fl_address_o, 32'h0);
        chk({tag, "_fl_command"}, fl_command_o, 32'h0);
        chk({tag, "_fl_commandtp"}, fl_commandtp_o, 32'h0);
        chk({tag, "_fl_datain"}, fl_datain_o, 32'h0);
        chk1({tag, "_timeout"}, timeout_o, 1'b0);
    endtask

    initial begin
        int n0;
        #2 arst_n_i = 1'b0;
        #6 check_zero("reset");
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;

        // Stray completion in IDLE must be ignored.
        tick(2);
        spur = 1;
        tick(1);
        spur = 0;
        tick(3);
        chk("spur_no_issue", 32'(issue_cnt), 32'd0);

        // Single cache read.
        cache_cmd_i   = 32'h0000000B;
        cache_cmdtp_i = 32'h00000003;
        sw_addr_i     = 32'hABCD0000;
        sw_datain_i   = 32'h77777777;
        push(0, 32'h00001234, 32'h0B, 32'h3, 32'h0, 32'hDEADBEEF, 10);
        cache_addr_i  = 24'h001234;
        cache_valid_i = 1'b1;
        wait_resp(1, "cache_read_timeout");
        cache_valid_i = 1'b0;
        chk("pin_cache_addr", last_issue_addr, 32'h00001234);
        chk("pin_cache_data", last_cache_data, 32'hDEADBEEF);

        // Single software read-ID.
        sw_addr_i   = 32'h0;
        sw_cmd_i    = 32'h0000009F;
        sw_cmdtp_i  = 32'h00000001;
        sw_datain_i = 32'h11223344;
        push(1, 32'h0, 32'h9F, 32'h1, 32'h11223344, 32'h00C22017, 6);
        sw_valid_i = 1'b1;
        tick(1);
        sw_valid_i = 1'b0;
        chk1("pin_sw_busy", sw_busy_o, 1'b1);
        wait_resp(2, "sw_read_timeout");
        tick(3);
        chk("pin_sw_rdata", sw_rdata_o, 32'h00C22017);
        chk1("pin_sw_idle", sw_busy_o, 1'b0);

        // Cache streaming while software waits: 4 cache, 1 sw, then cache.
        for (int i = 0; i < 4; i++)
            push(0, 32'h00000100, 32'h0B, 32'h3, 32'h0, 32'h1000 + i, 2 + i);
        push(1, 32'h12, 32'h05, 32'h2, 32'hCAFEF00D, 32'h000000A5, 3);
        push(0, 32'h00000100, 32'h0B, 32'h3, 32'h0, 32'h2000, 1);
        push(0, 32'h00000100, 32'h0B, 32'h3, 32'h0, 32'h2001, 4);
        sw_addr_i   = 32'h12;
        sw_cmd_i    = 32'h05;
        sw_cmdtp_i  = 32'h2;
        sw_datain_i = 32'hCAFEF00D;
        sw_valid_i  = 1'b1;
        tick(1);
        sw_valid_i    = 1'b0;
        cache_addr_i  = 24'h000100;
        cache_valid_i = 1'b1;
        wait_resp(9, "burst_timeout");
        cache_valid_i = 1'b0;
        chk("pin_burst_order", 32'(owner_log[6:0]), 32'h04);
        chk("pin_burst_sw_rdata", sw_rdata_o, 32'h000000A5);

        // Second sw start while busy is dropped.
        n0 = sw_done_cnt;
        sw_addr_i  = 32'h00400000;
        sw_cmd_i   = 32'h03;
        sw_cmdtp_i = 32'h4;
        sw_datain_i = 32'h0;
        push(1, 32'h00400000, 32'h03, 32'h4, 32'h0, 32'h55AA55AA, 8);
        sw_valid_i = 1'b1;
        tick(1);
        sw_valid_i = 1'b0;
        wait_issue(10);
        sw_addr_i  = 32'h00500000;
        sw_cmd_i   = 32'hAB;
        sw_valid_i = 1'b1;
        tick(1);
        sw_valid_i = 1'b0;
        wait_resp(10, "dup_timeout");
        tick(6);
        chk("pin_one_done", 32'(sw_done_cnt - n0), 32'd1);
        chk("pin_dup_rdata", sw_rdata_o, 32'h55AA55AA);

        // Reset while waiting on the controller.
        push(0, 32'h00000200, 32'h0B, 32'h3, 32'h0, 32'h33333333, 40);
        cache_addr_i  = 24'h000200;
        cache_valid_i = 1'b1;
        wait_issue(11);
        tick(3);
        @(posedge clk_i);
        #3 arst_n_i = 1'b0;
        cache_valid_i = 1'b0;
        #1 check_zero("midreset");
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        n0 = issue_cnt;
        tick(8);
        chk("post_reset_quiet", 32'(issue_cnt), 32'(n0));

`ifdef IOB_SPI_FLASH_ARB_TIMEOUT_EN
        // Controller never answers: watchdog completes the read.
        push(0, 32'h00000300, 32'h0B, 32'h3, 32'h0, 32'h0, 0);
        cache_addr_i  = 24'h000300;
        cache_valid_i = 1'b1;
        wait_resp(12, "watchdog_timeout");
        cache_valid_i = 1'b0;
        chk("pin_tmo_data", last_cache_data, 32'hFFFFFFFF);
        tick(5);
        chk1("pin_tmo_sticky", timeout_o, 1'b1);
        @(posedge clk_i);
        #3 arst_n_i = 1'b0;
        #1 chk1("pin_tmo_reset", timeout_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        tick(3);
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
